// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_IF = 2'b01,
        ST_BUSY_LS = 2'b10,
        ST_RESP    = 2'b11
    } arb_state_e;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_IF   = 2'b01;
    localparam logic [1:0] OWNER_LS   = 2'b10;

    // Read data returned on any errored completion
    localparam int unsigned ERR_RDATA = 0;

    // Word accesses only: any set low address bit is an error
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating wait counter; expired flags that TIMEOUT stalled cycles elapsed.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear has priority, otherwise count up and stick at LIMIT
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory/IO port between fetch and load/store,
// one transaction at a time, with watchdog abort and alignment check.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 32,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    owner,
    output logic          stall
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [DW-1:0] ERR_DATA   = DW'(ERR_RDATA);

    arb_state_e    state_q, state_d;
    logic          resp_ls_q, resp_ls_d;
    logic          err_q, err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          grant_ls;
    logic          grant_if;
    logic [AW-1:0] sel_addr;
    logic          busy;
    logic          wd_expired;

    assign busy = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_LS);

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!busy),
        .enable (busy && !mem_ready),
        .expired(wd_expired)
    );

    // Next-state, arbitration and transaction bookkeeping
    always_comb begin
        state_d     = state_q;
        resp_ls_d   = resp_ls_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        starve_d    = starve_q;
        grant_ls    = 1'b0;
        grant_if    = 1'b0;
        sel_addr    = '0;

        unique case (state_q)
            ST_IDLE: begin
                grant_ls = ls_req && (!if_req || (starve_q != STARVE_MAX));
                grant_if = if_req && !grant_ls;
                sel_addr = grant_ls ? ls_addr : if_addr;

                // Any cycle that is not "fetch waiting but ls won" resets the count
                if (if_req && grant_ls) begin
                    starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                end

                if (grant_ls || grant_if) begin
                    resp_ls_d = grant_ls;
                    if (addr_misaligned(sel_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                        if (grant_ls) begin
                            ls_rdata_d = ERR_DATA;
                        end else begin
                            if_rdata_d = ERR_DATA;
                        end
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = grant_ls && ls_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = grant_ls ? ls_wdata : '0;
                        state_d     = grant_ls ? ST_BUSY_LS : ST_BUSY_IF;
                    end
                end
            end

            ST_BUSY_IF, ST_BUSY_LS: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_RESP;
                    if (!mem_we_q) begin
                        if (resp_ls_q) begin
                            ls_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else if (wd_expired) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                    if (resp_ls_q) begin
                        ls_rdata_d = ERR_DATA;
                    end else begin
                        if_rdata_d = ERR_DATA;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            resp_ls_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            resp_ls_q   <= resp_ls_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            starve_q    <= starve_d;
        end
    end

    // Owner follows the busy state; idle and response cycles report none
    always_comb begin
        owner = OWNER_IDLE;
        if (state_q == ST_BUSY_IF) begin
            owner = OWNER_IF;
        end else if (state_q == ST_BUSY_LS) begin
            owner = OWNER_LS;
        end
    end

    assign if_ack    = (state_q == ST_RESP) && !resp_ls_q;
    assign ls_ack    = (state_q == ST_RESP) && resp_ls_q;
    assign if_err    = if_ack && err_q;
    assign ls_err    = ls_ack && err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (if_req && !if_ack) || (ls_req && !ls_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  owner;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cycles;

    mem_port_arbiter #(
        .DW          (32),
        .AW          (32),
        .TIMEOUT     (8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .ls_err   (ls_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .owner    (owner),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=0x00000000 exp=0x00000001");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd0);
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_ls_ack", {31'd0, ls_ack}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        step();

        // Single fetch, two wait cycles
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        step();
        check("f1_mem_req", {31'd0, mem_req}, 32'd1);
        check("f1_mem_addr", mem_addr, 32'h40);
        check("f1_mem_we", {31'd0, mem_we}, 32'd0);
        check("f1_owner", {30'd0, owner}, 32'd1);
        check("f1_stall", {31'd0, stall}, 32'd1);
        step();
        step();
        check("f1_wait_no_ack", {31'd0, if_ack}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h2008_0005;
        step();
        mem_ready = 1'b0;
        check("f1_ack", {31'd0, if_ack}, 32'd1);
        check("f1_rdata", if_rdata, 32'h2008_0005);
        check("f1_err", {31'd0, if_err}, 32'd0);
        check("f1_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("f1_stall_ack", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        step();
        check("f1_ack_one_cycle", {31'd0, if_ack}, 32'd0);
        check("f1_rdata_held", if_rdata, 32'h2008_0005);

        // Simultaneous requests: store first, then fetch after turnaround
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h0000_0100;
        ls_wdata = 32'hCAFE_F00D;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0044;
        step();
        check("st_owner", {30'd0, owner}, 32'd2);
        check("st_mem_we", {31'd0, mem_we}, 32'd1);
        check("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        check("st_mem_addr", mem_addr, 32'h100);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ready = 1'b0;
        check("st_ls_ack", {31'd0, ls_ack}, 32'd1);
        check("st_ls_err", {31'd0, ls_err}, 32'd0);
        check("st_if_no_ack", {31'd0, if_ack}, 32'd0);
        check("st_rdata_kept", ls_rdata, 32'd0);
        check("st_stall_if", {31'd0, stall}, 32'd1);
        check("st_mem_we_drop", {31'd0, mem_we}, 32'd0);
        ls_req = 1'b0;
        ls_we  = 1'b0;
        step();
        check("st_turnaround_owner", {30'd0, owner}, 32'd0);
        check("st_turnaround_req", {31'd0, mem_req}, 32'd0);
        step();
        check("st_fetch_owner", {30'd0, owner}, 32'd1);
        check("st_fetch_addr", mem_addr, 32'h44);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        mem_ready = 1'b0;
        check("st_fetch_ack", {31'd0, if_ack}, 32'd1);
        check("st_fetch_rdata", if_rdata, 32'h1111_2222);
        if_req = 1'b0;
        step();

        // Starvation: fetch wins the fifth arbitration
        if_req  = 1'b1;
        if_addr = 32'h0000_0048;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            ls_addr = 32'h0000_0200 + 32'(k * 4);
            step();
            if (k < 5) begin
                check($sformatf("sv_owner_ls%0d", k), {30'd0, owner}, 32'd2);
                check($sformatf("sv_addr_ls%0d", k), mem_addr, 32'h200 + 32'(k * 4));
            end else begin
                check("sv_owner_fetch", {30'd0, owner}, 32'd1);
                check("sv_addr_fetch", mem_addr, 32'h48);
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            mem_ready = 1'b1;
            mem_rdata = 32'hD000_0000 + 32'(k);
            step();
            mem_ready = 1'b0;
            if (k < 5) begin
                check($sformatf("sv_ls_ack%0d", k), {31'd0, ls_ack}, 32'd1);
                check($sformatf("sv_ls_rdata%0d", k), ls_rdata, 32'hD000_0000 + 32'(k));
            end else begin
                check("sv_if_ack_dropped_req", {31'd0, if_ack}, 32'd1);
                check("sv_if_rdata", if_rdata, 32'hD000_0005);
            end
            step();
        end

        // Misaligned load: immediate error response, no memory access
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_0102;
        step();
        check("mis_mem_req", {31'd0, mem_req}, 32'd0);
        check("mis_ls_ack", {31'd0, ls_ack}, 32'd1);
        check("mis_ls_err", {31'd0, ls_err}, 32'd1);
        check("mis_ls_rdata", ls_rdata, 32'd0);
        ls_req = 1'b0;
        step();
        check("mis_ack_one_cycle", {31'd0, ls_ack}, 32'd0);

        // Stray ready while idle is ignored
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("idle_ready_owner", {30'd0, owner}, 32'd0);
        check("idle_ready_ack", {31'd0, if_ack | ls_ack}, 32'd0);

        // Watchdog timeout with TIMEOUT=8
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        step();
        req_cycles = 0;
        for (int i = 0; i < 20 && mem_req; i++) begin
            req_cycles++;
            step();
        end
        check("to_req_cycles", 32'(req_cycles), 32'd9);
        check("to_if_ack", {31'd0, if_ack}, 32'd1);
        check("to_if_err", {31'd0, if_err}, 32'd1);
        check("to_if_rdata", if_rdata, 32'd0);
        if_req = 1'b0;
        step();

        // Ready in the same cycle the watchdog expires: ready wins
        if_req  = 1'b1;
        if_addr = 32'h0000_0084;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
        end
        check("tr_still_busy", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_0001;
        step();
        mem_ready = 1'b0;
        check("tr_if_ack", {31'd0, if_ack}, 32'd1);
        check("tr_if_err", {31'd0, if_err}, 32'd0);
        check("tr_if_rdata", if_rdata, 32'h7777_0001);
        if_req = 1'b0;
        step();

        // Reset during BUSY_LS, then pending fetch is served
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_0300;
        if_req  = 1'b1;
        if_addr = 32'h0000_0090;
        step();
        check("rb_owner_ls", {30'd0, owner}, 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check("rb_mem_req_async", {31'd0, mem_req}, 32'd0);
        check("rb_owner_async", {30'd0, owner}, 32'd0);
        check("rb_ack_async", {31'd0, if_ack | ls_ack}, 32'd0);
        check("rb_if_rdata_clr", if_rdata, 32'd0);
        ls_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("rb_fetch_owner", {30'd0, owner}, 32'd1);
        check("rb_fetch_addr", mem_addr, 32'h90);
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A_A5A5;
        step();
        mem_ready = 1'b0;
        check("rb_fetch_ack", {31'd0, if_ack}, 32'd1);
        check("rb_fetch_rdata", if_rdata, 32'h5A5A_A5A5);
        check("rb_ls_no_ack", {31'd0, ls_ack}, 32'd0);
        if_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory/IO port (addr/din/dout/DMWr with MIO_ready handshake) between the instruction-fetch requester and the load/store requester of the MIPS core.
- Sequences one transaction at a time with a handshake toward the memory/IO controller.
- Provides a watchdog timeout and a misalignment check.
- Returns read data and completion pulses to each requester; the core stalls on them.

Parameters:
- DW, 32, data width
- AW, 32, address width
- TIMEOUT, 255, max cycles waiting for mem_ready before abort (1..65535)
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_ack
- if_addr  in  AW  fetch address; stable while if_req
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DW  fetched word; valid with if_ack, held until next if_ack
- if_err  out  1  with if_ack: timeout or misaligned
- ls_req  in  1  load/store request; level, held until ls_ack
- ls_we  in  1  1 = store
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_ack  out  1  one-cycle completion pulse
- ls_rdata  out  DW  load data; valid with ls_ack, held
- ls_err  out  1  with ls_ack: timeout or misaligned
- mem_req  out  1  transaction active toward memory/IO
- mem_we  out  1  write strobe (DMWr)
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, sampled when mem_ready=1
- mem_ready  in  1  memory/IO completion (MIO_ready)
- owner  out  2  00 idle, 01 fetch, 10 load/store
- stall  out  1  (if_req & ~if_ack) | (ls_req & ~ls_ack), combinational

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0, including rdata registers, starve counter and watchdog. Deassertion is synchronous to clk. Reset mid-transaction drops mem_req immediately; the transaction is abandoned and no ack is issued.
- States: IDLE, BUSY_IF, BUSY_LS, RESP.
- IDLE arbitration, evaluated each cycle:
  - ls_req wins over if_req, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments when both request and ls wins; clears when fetch is granted or if_req=0; saturates.
- Grant, normal address (addr[1:0]==0):
  - Register addr, we (0 for fetch) and wdata.
  - Next cycle: mem_req=1, owner set, state BUSY_x.
- Grant, misaligned (addr[1:0]!=0):
  - No memory access.
  - Go to RESP with err=1, rdata=0.
- BUSY_x:
  - mem_* outputs held constant.
  - Watchdog counts from 0 each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata (reads only; stores leave rdata unchanged) and go to RESP with err=0. mem_req deasserts the same edge.
  - Watchdog reaches TIMEOUT: drop mem_req, go to RESP with err=1, rdata=0.
  - mem_ready and timeout in the same cycle: ready wins.
- RESP: pulse x_ack=1 for exactly one cycle with x_err; owner=00; return to IDLE.
  - No new grant in the RESP cycle (1-cycle turnaround), so a requester's still-high req is not re-granted.
  - Latency: req seen at edge N → mem_req high after N → ready at cycle M → ack in cycle M+1. Minimum 3 cycles from req to ack.
- Requester drops req mid-transaction: the transaction still completes and ack still pulses.
- mem_ready while in IDLE or RESP: ignored.
- Watchdog and starve counters do not wrap; both saturate.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE, BUSY_IF, BUSY_LS, RESP)
  - OWNER_* constants
  - ERR_RDATA = 0
- One sub-module, bus_watchdog:
  - inputs: clk, reset, clear, enable
  - output: expired, asserted when count == TIMEOUT
  - parameter: TIMEOUT

Test Plan:
- Single fetch: if_addr=0x0000_0040, mem_ready after 2 waits, mem_rdata=0x2008_0005 → mem_addr=0x40, mem_we=0, if_ack one cycle with if_rdata=0x2008_0005, if_err=0.
- Both request in the same cycle; ls store addr 0x0000_0100, data 0xCAFE_F00D, ready immediate → store served first (mem_we=1, mem_wdata=0xCAFE_F00D), ls_ack; fetch granted after the RESP cycle.
- ls_req held continuously with back-to-back loads while if_req is high → fetch granted on the 5th arbitration (STARVE_LIMIT=4).
- Load to 0x0000_0102 → no mem_req; ls_ack with ls_err=1 and ls_rdata=0 two cycles after the request.
- mem_ready never asserted, TIMEOUT=8 → mem_req high for 9 cycles, then drops; if_ack with if_err=1.
- reset pulled low while BUSY_LS → mem_req, owner and ack go to 0 asynchronously; after release, a pending if_req is served normally.
